tour_cmd: RTL

TOUR_CMD -- requirements
Module: tour_cmd

---
 rtl/tour_pkg.sv | 31 +++
 rtl/knight_move_decode.sv | 43 ++++
 rtl/tour_cmd.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVert,
    StVertWait,
    StHorz,
    StHorzWait
  } tour_state_e;

  localparam logic [3:0] OpMove        = 4'h2;
  localparam logic [3:0] OpMoveFanfare = 4'h3;

  localparam logic [7:0] HeadNorth = 8'h00;
  localparam logic [7:0] HeadWest  = 8'h3F;
  localparam logic [7:0] HeadSouth = 8'h7F;
  localparam logic [7:0] HeadEast  = 8'hBF;

  localparam logic [7:0] RespAck  = 8'h5A;
  localparam logic [7:0] RespDone = 8'hA5;

  localparam int unsigned LAST_MOVE = 23;

  // Pack a command word: opcode, heading, square count.
  function automatic logic [15:0] make_cmd(input logic [3:0] op, input logic [7:0] head,
                                           input logic [3:0] squares);
    return {op, head, squares};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Combinational decode of a one-hot knight move into vertical and horizontal leg commands.
module knight_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        valid
);

  logic [2:0] sel;
  logic       dx_pos;
  logic       dy_pos;
  logic [3:0] dx_mag;
  logic [3:0] dy_mag;

  // Pick the lowest set bit, then map it to a signed (dx,dy) pair.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (move[i]) sel = 3'(i);
    end
    dx_pos = 1'b0;
    dy_pos = 1'b0;
    dx_mag = 4'd0;
    dy_mag = 4'd0;
    unique case (sel)
      3'd0: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      3'd1: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      3'd2: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      3'd3: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
      3'd4: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
      3'd5: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
      3'd6: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
      3'd7: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      default: ;
    endcase
    valid    = |move;
    vert_cmd = make_cmd(OpMove, dy_pos ? HeadNorth : HeadSouth, dy_mag);
    horz_cmd = make_cmd(OpMoveFanfare, dx_pos ? HeadEast : HeadWest, dx_mag);
  end

endmodule

// File: rtl/tour_cmd.sv
// Sequences a 24-move knight's tour into motion commands, muxed with UART traffic when idle.
module tour_cmd
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tour_go,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  tour_state_e state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [15:0] tour_cmd_q, tour_cmd_d;
  logic [15:0] horz_q, horz_d;
  logic        tour_rdy_q, tour_rdy_d;

  logic [15:0] dec_vert;
  logic [15:0] dec_horz;
  logic        dec_valid;
  logic        last_move;

  knight_move_decode u_decode (
    .move     (move),
    .vert_cmd (dec_vert),
    .horz_cmd (dec_horz),
    .valid    (dec_valid)
  );

  assign last_move = (mv_indx_q == 5'(LAST_MOVE));

  // State and tour registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mv_indx_q  <= 5'd0;
      tour_cmd_q <= 16'd0;
      horz_q     <= 16'd0;
      tour_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      tour_cmd_q <= tour_cmd_d;
      horz_q     <= horz_d;
      tour_rdy_q <= tour_rdy_d;
    end
  end

  // Next-state: each move is a vertical leg then a horizontal leg, each a rdy/clr/resp handshake.
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    tour_cmd_d = tour_cmd_q;
    horz_d     = horz_q;
    tour_rdy_d = tour_rdy_q;
    unique case (state_q)
      StIdle: begin
        if (tour_go) begin
          mv_indx_d = 5'd0;
          state_d   = StVert;
        end
      end
      StVert: begin
        // First cycle in VERT samples the move addressed by the now-settled mv_indx.
        if (!tour_rdy_q) begin
          if (!dec_valid) begin
            state_d = StIdle;
          end else begin
            tour_cmd_d = dec_vert;
            horz_d     = dec_horz;
            tour_rdy_d = 1'b1;
          end
        end else if (clr_cmd_rdy) begin
          tour_rdy_d = 1'b0;
          state_d    = StVertWait;
        end
      end
      StVertWait: begin
        if (send_resp) begin
          tour_cmd_d = horz_q;
          tour_rdy_d = 1'b1;
          state_d    = StHorz;
        end
      end
      StHorz: begin
        if (clr_cmd_rdy) begin
          tour_rdy_d = 1'b0;
          state_d    = StHorzWait;
        end
      end
      StHorzWait: begin
        if (send_resp) begin
          if (last_move) begin
            state_d = StIdle;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = StVert;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output mux: UART pass-through when idle, tour registers otherwise.
  always_comb begin
    mv_indx = mv_indx_q;
    if (state_q == StIdle) begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
      resp             = RespDone;
    end else begin
      cmd              = tour_cmd_q;
      cmd_rdy          = tour_rdy_q;
      clr_cmd_rdy_UART = 1'b0;
      resp             = (last_move && (state_q == StHorz || state_q == StHorzWait)) ?
                         RespDone : RespAck;
    end
  end

endmodule
